// File: rtl/cu_pkg.sv
// Shared definitions for the cpu_control_unit sequencer: opcodes, ALU and PC
// control codes, FSM states and instruction field positions.
package cu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_MVI  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_XOR    = 3'b100;
  localparam logic [2:0] ALU_PASS_B = 3'b111;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_WB     = 3'd5,
    S_PCUPD  = 3'd6,
    S_HALTED = 3'd7
  } cu_state_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
    reg_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Opcode decoder for cpu_control_unit: instruction class plus ALU controls.
// Purely combinational; reserved opcodes A-E flag illegal and behave as NOP.
module cu_decoder
  import cu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_alu,
  output logic       is_jmp,
  output logic       is_halt,
  output logic       illegal,
  output logic [2:0] alu_func,
  output logic       alu_in_sel
);

  always_comb begin
    is_alu     = 1'b0;
    is_jmp     = 1'b0;
    is_halt    = 1'b0;
    illegal    = 1'b0;
    alu_func   = ALU_ADD;
    alu_in_sel = 1'b0;
    case (opcode)
      OP_NOP:  ;
      OP_MOV:  begin is_alu = 1'b1; alu_func = ALU_PASS_B; end
      OP_MVI:  begin is_alu = 1'b1; alu_func = ALU_PASS_B; alu_in_sel = 1'b1; end
      OP_ADD:  is_alu = 1'b1;
      OP_ADDI: begin is_alu = 1'b1; alu_in_sel = 1'b1; end
      OP_SUB:  begin is_alu = 1'b1; alu_func = ALU_SUB; end
      OP_AND:  begin is_alu = 1'b1; alu_func = ALU_AND; end
      OP_OR:   begin is_alu = 1'b1; alu_func = ALU_OR; end
      OP_XOR:  begin is_alu = 1'b1; alu_func = ALU_XOR; end
      OP_JMP:  is_jmp = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle instruction sequencer; every output is registered. NOP/JMP take 3
// cycles, ALU ops 5 + datapath wait. CU_WDOG_EN adds a WAIT watchdog that halts.
module cpu_control_unit
  import cu_pkg::*;
#(
  parameter int DWIDTH      = 16,
  parameter int WDOG_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DWIDTH-1:0] instr,
  input  logic              dp_done,
  output logic              en_in,
  output logic              en_pc_pulse,
  output logic [1:0]        pc_ctrl,
  output logic [7:0]        offset_addr,
  output logic [7:0]        offset,
  output logic              alu_in_sel,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [3:0]        reg_en,
  output logic [2:0]        alu_func,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  cu_state_e         state;
  logic [DWIDTH-1:0] ir;

  logic       dec_is_alu;
  logic       dec_is_jmp;
  logic       dec_is_halt;
  logic       dec_illegal;
  logic [2:0] dec_alu_func;
  logic       dec_alu_in_sel;

`ifdef CU_WDOG_EN
  localparam logic [3:0] WDOG_LAST = 4'(WDOG_CYCLES - 1);
  logic [3:0] wdog_cnt;
`endif

  cu_decoder u_decoder (
    .opcode     (ir[OPC_MSB:OPC_LSB]),
    .is_alu     (dec_is_alu),
    .is_jmp     (dec_is_jmp),
    .is_halt    (dec_is_halt),
    .illegal    (dec_illegal),
    .alu_func   (dec_alu_func),
    .alu_in_sel (dec_alu_in_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ir          <= '0;
      en_in       <= 1'b0;
      en_pc_pulse <= 1'b0;
      pc_ctrl     <= PC_HOLD;
      offset_addr <= '0;
      offset      <= '0;
      alu_in_sel  <= 1'b0;
      rd          <= '0;
      rs          <= '0;
      reg_en      <= '0;
      alu_func    <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
`ifdef CU_WDOG_EN
      wdog_cnt    <= '0;
`endif
    end else begin
      // Strobes are single-cycle: they default low and are raised for the
      // state being entered, so each appears exactly in its own state.
      en_in       <= 1'b0;
      en_pc_pulse <= 1'b0;
      pc_ctrl     <= PC_HOLD;
      reg_en      <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          ir    <= instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          rd          <= ir[RD_MSB:RD_LSB];
          rs          <= ir[RS_MSB:RS_LSB];
          offset      <= ir[IMM_MSB:IMM_LSB];
          offset_addr <= ir[IMM_MSB:IMM_LSB];
          alu_func    <= dec_alu_func;
          alu_in_sel  <= dec_alu_in_sel;
          if (dec_illegal) err <= 1'b1;
          if (dec_is_halt) begin
            state  <= S_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (dec_is_alu) begin
            state <= S_EXEC;
            en_in <= 1'b1;
          end else begin
            state       <= S_PCUPD;
            en_pc_pulse <= 1'b1;
            pc_ctrl     <= dec_is_jmp ? PC_LOAD : PC_INC;
          end
        end
        S_EXEC: begin
          state <= S_WAIT;
`ifdef CU_WDOG_EN
          wdog_cnt <= '0;
`endif
        end
        S_WAIT: begin
          // A completion in the expiry cycle still takes the normal path.
          if (dp_done) begin
            state  <= S_WB;
            reg_en <= reg_onehot(rd);
          end
`ifdef CU_WDOG_EN
          else if (wdog_cnt == WDOG_LAST) begin
            state  <= S_HALTED;
            err    <= 1'b1;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + 4'd1;
          end
`endif
        end
        S_WB: begin
          state       <= S_PCUPD;
          en_pc_pulse <= 1'b1;
          pc_ctrl     <= PC_INC;
        end
        S_PCUPD: begin
          state <= S_FETCH;
        end
        S_HALTED: ;
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed table, random program against a model,
// and hand sequences for reset, halt and the long datapath wait.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] instr;
  logic        dp_done;
  logic        en_in, en_pc_pulse, alu_in_sel, busy, halted, err;
  logic [1:0]  pc_ctrl, rd, rs;
  logic [7:0]  offset_addr, offset;
  logic [3:0]  reg_en;
  logic [2:0]  alu_func;

  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .dp_done(dp_done),
    .en_in(en_in), .en_pc_pulse(en_pc_pulse), .pc_ctrl(pc_ctrl),
    .offset_addr(offset_addr), .offset(offset), .alu_in_sel(alu_in_sel),
    .rd(rd), .rs(rs), .reg_en(reg_en), .alu_func(alu_func),
    .busy(busy), .halted(halted), .err(err)
  );

  typedef struct {
    logic [15:0] instr;
    int          d;       // dp_done this many cycles after en_in
    bit          stray;   // extra dp_done pulses outside WAIT
    int          cycles;
    logic [3:0]  reg_en;
    logic [1:0]  pc_ctrl;
    logic [2:0]  func;
    logic        sel;
    logic        err;     // err after this instruction
    bit          halt;
  } vec_t;

  vec_t tbl[12];
  int   n_pass = 0;
  int   n_total = 0;
  logic err_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [34:0] all_outs();
    return {en_in, en_pc_pulse, pc_ctrl, offset_addr, offset, alu_in_sel,
            rd, rs, reg_en, alu_func, busy, halted, err};
  endfunction

  // Reference: instruction-level expectations straight from the opcode table.
  function automatic vec_t model(input logic [15:0] w, input int d, input bit stray,
                                 input logic err_in);
    vec_t v;
    logic [3:0] op;
    bit alu;
    op      = w[15:12];
    alu     = (op >= 4'h1) && (op <= 4'h8);
    v.instr = w;
    v.d     = d;
    v.stray = stray;
    v.halt  = (op == 4'hF);
    v.cycles  = alu ? 5 + d : 3;
    v.reg_en  = alu ? (4'b0001 << w[11:10]) : 4'b0000;
    v.pc_ctrl = (op == 4'h9) ? 2'b10 : 2'b01;
    case (op)
      4'h1, 4'h2: v.func = 3'b111;
      4'h5:       v.func = 3'b001;
      4'h6:       v.func = 3'b010;
      4'h7:       v.func = 3'b011;
      4'h8:       v.func = 3'b100;
      default:    v.func = 3'b000;
    endcase
    v.sel = (op == 4'h2) || (op == 4'h4);
    v.err = err_in | ((op >= 4'hA) && (op <= 4'hE));
    return v;
  endfunction

  // Entered at the start of a FETCH cycle; leaves at the start of the next one.
  task automatic run_vec(input vec_t v, input string tag, input bit rnd);
    int total;
    bit alu;
    bit pc;
    logic [10:0] e;
    total = v.halt ? 3 : v.cycles;
    alu   = (v.reg_en != 4'b0000);
    instr = v.instr;
    for (int t = 0; t < total; t++) begin
      if (rnd) start = 1'($urandom_range(0, 1));
      dp_done = (alu && t == 2 + v.d) || (v.stray && (t == 1 || t == total - 1));
      pc = !v.halt && (t == total - 1);
      e = {alu && t == 2, pc, pc ? v.pc_ctrl : 2'b00,
           (alu && t == total - 2) ? v.reg_en : 4'b0000,
           !(v.halt && t == 2), v.halt && t == 2, (t >= 2) ? v.err : err_prev};
      chk($sformatf("%s strobes t%0d", tag, t),
          {en_in, en_pc_pulse, pc_ctrl, reg_en, busy, halted, err}, e);
      if (!v.halt && (t == 2 || t == total - 1)) begin
        chk($sformatf("%s fields t%0d", tag, t), {rd, rs, offset, offset_addr},
            {v.instr[11:10], v.instr[9:8], v.instr[7:0], v.instr[7:0]});
        if (alu) chk($sformatf("%s alu t%0d", tag, t), {alu_func, alu_in_sel}, {v.func, v.sel});
      end
      step();
    end
    dp_done  = 1'b0;
    err_prev = v.err;
  endtask

  initial begin
    vec_t rv;
    logic [15:0] w;

    tbl[0]  = '{16'h3600, 3, 0,  8, 4'b0010, 2'b01, 3'b000, 1'b0, 1'b0, 0};
    tbl[1]  = '{16'h2C5A, 2, 0,  7, 4'b1000, 2'b01, 3'b111, 1'b1, 1'b0, 0};
    tbl[2]  = '{16'h9042, 0, 0,  3, 4'b0000, 2'b10, 3'b000, 1'b0, 1'b0, 0};
    tbl[3]  = '{16'h0000, 0, 1,  3, 4'b0000, 2'b01, 3'b000, 1'b0, 1'b0, 0};
    tbl[4]  = '{16'h5E00, 1, 0,  6, 4'b1000, 2'b01, 3'b001, 1'b0, 1'b0, 0};
    tbl[5]  = '{16'h6100, 4, 0,  9, 4'b0001, 2'b01, 3'b010, 1'b0, 1'b0, 0};
    tbl[6]  = '{16'h7900, 3, 1,  8, 4'b0100, 2'b01, 3'b011, 1'b0, 1'b0, 0};
    tbl[7]  = '{16'h8400, 2, 0,  7, 4'b0010, 2'b01, 3'b100, 1'b0, 1'b0, 0};
    tbl[8]  = '{16'h1B00, 1, 0,  6, 4'b0100, 2'b01, 3'b111, 1'b0, 1'b0, 0};
    tbl[9]  = '{16'h4DFF, 5, 0, 10, 4'b1000, 2'b01, 3'b000, 1'b1, 1'b0, 0};
    tbl[10] = '{16'hB000, 0, 0,  3, 4'b0000, 2'b01, 3'b000, 1'b0, 1'b1, 0};
    tbl[11] = '{16'h9000, 0, 0,  3, 4'b0000, 2'b10, 3'b000, 1'b0, 1'b1, 0};

    rst = 1'b1; start = 1'b0; dp_done = 1'b0; instr = 16'h0000;
    #12;
    chk("reset outs", all_outs(), 35'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("idle outs %0d", i), all_outs(), 35'd0);
      step();
    end
    start = 1'b1;
    step();

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i), 0);

    for (int i = 0; i < 40; i++) begin
      w  = {4'($urandom_range(0, 14)), 12'($urandom)};
      rv = model(w, $urandom_range(1, 6), 1'($urandom_range(0, 1)), err_prev);
      run_vec(rv, $sformatf("rnd%0d", i), 1);
    end

    start = 1'b1;
    run_vec(model(16'hF000, 0, 0, err_prev), "halt", 0);
    for (int i = 0; i < 8; i++) begin
      start = 1'($urandom_range(0, 1));
      chk($sformatf("halt hold %0d", i),
          {halted, busy, en_in, en_pc_pulse, reg_en, err}, {1'b1, 7'b0, err_prev});
      step();
    end

    // Async reset in the middle of an ADD's WAIT, with a coincident dp_done.
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b1; instr = 16'h3600;
    step();
    step();
    step();
    chk("rst seq en_in", en_in, 1'b1);
    step();
    step();
    rst = 1'b1; dp_done = 1'b1;
    #1;
    chk("rst async outs", all_outs(), 35'd0);
    step();
    dp_done = 1'b0; rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst idle %0d", i), all_outs(), 35'd0);
      step();
    end
    start = 1'b1;
    step();
    err_prev = 1'b0;
    run_vec(tbl[0], "post rst", 0);

    // Datapath never completes.
    instr = 16'h3600;
    step();
    step();
    chk("stall en_in", en_in, 1'b1);
    step();
`ifdef CU_WDOG_EN
    for (int t = 3; t < 18; t++) begin
      chk($sformatf("wdog wait t%0d", t), {busy, halted, err, reg_en, en_pc_pulse}, 8'b1000_0000);
      step();
    end
    chk("wdog expire", {busy, halted, err, reg_en, en_pc_pulse}, 8'b0110_0000);
    step();
    chk("wdog stay", {busy, halted, err, reg_en, en_pc_pulse}, 8'b0110_0000);
`else
    for (int i = 0; i < 110; i++) begin
      chk($sformatf("long wait %0d", i), {busy, halted, err, reg_en, en_pc_pulse}, 8'b1000_0000);
      step();
    end
    dp_done = 1'b1;
    step();
    dp_done = 1'b0;
    chk("late wb", {reg_en, en_pc_pulse}, 5'b0010_0);
    step();
    chk("late pcupd", {reg_en, en_pc_pulse, pc_ctrl}, 7'b0000_1_01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Instruction sequencer driving the 16-bit datapath (PC, register group, ALU operand mux, ALU) from its upstream side. Latches the instruction word addressed by the PC, decodes it, and steps through a multi-cycle FSM. The FSM issues the datapath enable pulse, waits for the datapath completion pulse, writes the result back to the register file, and advances or loads the PC. It is the sole source of every datapath control input.

## Interface
- DWIDTH, 16, instruction word width; the encoding uses bits [15:0]
- WDOG_CYCLES, 15, watchdog limit in cycles (used only with CU_WDOG_EN)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; starts execution from IDLE
- instr  in  DWIDTH  instruction word at current pc_out (combinational instruction ROM)
- dp_done  in  1  datapath completion pulse (ALU en_out)
- en_in  out  1  one-cycle pulse that starts a datapath operation
- en_pc_pulse  out  1  one-cycle PC update strobe
- pc_ctrl  out  2  00 hold, 01 increment, 10 load offset_addr, 11 reserved (never driven)
- offset_addr  out  8  jump target
- offset  out  8  immediate operand
- alu_in_sel  out  1  0 = rs_q, 1 = immediate
- rd, rs  out  2 each  destination / source register index
- reg_en  out  4  one-hot register write enable
- alu_func  out  3  ALU function code
- busy  out  1  high in every state except IDLE and HALTED
- halted  out  1  high in HALTED
- err  out  1  sticky; set on illegal opcode or watchdog expiry

## Operation
- Encoding: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm / jump target.
- Opcodes and their controls:
  - 0 NOP.
  - 1 MOV: alu_func PASS_B, sel 0.
  - 2 MVI: PASS_B, sel 1.
  - 3 ADD: sel 0.
  - 4 ADDI: sel 1.
  - 5 SUB, 6 AND, 7 OR, 8 XOR: sel 0.
  - 9 JMP.
  - F HALT.
  - A–E illegal: set err, execute as NOP.
- alu_func codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 111 PASS_B.
- FSM states: IDLE, FETCH, DECODE, EXEC, WAIT, WB, PCUPD, HALTED.
  - IDLE → FETCH when start=1.
  - FETCH: latch instr into IR.
  - DECODE: register rd, rs, offset, offset_addr, alu_func, alu_in_sel from IR. ALU ops → EXEC. NOP, JMP, illegal → PCUPD. HALT → HALTED.
  - EXEC: en_in=1 for exactly one cycle → WAIT.
  - WAIT: hold until dp_done=1 → WB.
  - WB: reg_en = one-hot(rd) for one cycle → PCUPD.
  - PCUPD: en_pc_pulse=1 for one cycle; pc_ctrl=10 for JMP, 01 otherwise → FETCH.
  - HALTED: terminal until rst. start is ignored.
- Decoded fields are stable from the cycle after DECODE through PCUPD.
- Outside its strobe cycle, pc_ctrl is 00 and reg_en is 0000.
- dp_done outside WAIT: ignored.
- start while busy: ignored.
- Holding start high does not re-trigger; the unit runs continuously until HALT.

## Timing
- Reset values: every output 0, state IDLE, IR 0, err 0.
- rst mid-instruction: all outputs go to 0 asynchronously. No partial write or PC strobe occurs after reset asserts.
- All outputs are registered. No combinational path from any input to any output.
- NOP / JMP / illegal: 3 cycles (FETCH, DECODE, PCUPD).
- ALU op: 5 cycles plus the WAIT length. With a 3-cycle datapath (dp_done 3 cycles after en_in) this is 8 cycles per instruction.
- reg_en asserts in the cycle after dp_done, while alu_out is held valid.
- dp_done coincident with rst: rst wins.

## Configuration
- CU_WDOG_EN defined: a 4-bit counter clears on entry to WAIT and increments in each WAIT cycle.
  - When it reaches WDOG_CYCLES without dp_done: set err, go to HALTED, no reg_en and no PC strobe.
  - dp_done in the same cycle as expiry wins.
- CU_WDOG_EN undefined: no counter; WAIT waits indefinitely.

## Structure
- Shared package cu_pkg:
  - opcode constants
  - alu_func codes
  - pc_ctrl codes (PC_HOLD, PC_INC, PC_LOAD)
  - FSM state enum
  - field-slice localparams
- Sub-module cu_decoder: purely combinational. Maps opcode to is_alu, is_jmp, is_halt, illegal, alu_func, alu_in_sel. Instantiated once, fed from IR.

## Test plan
- Reset mid-WAIT of ADD → all outputs 0 immediately; FSM restarts only after start.
- start, instr=16'h3600 (ADD r1,r2), dp_done 3 cycles after en_in → en_in pulse at cycle 2, reg_en=0010 at cycle 6, en_pc_pulse with pc_ctrl=01 at cycle 7, next FETCH at cycle 8.
- instr=16'h2C5A (MVI r3,0x5A) → alu_in_sel=1, offset=0x5A, alu_func=111, reg_en=1000.
- instr=16'h9042 (JMP 0x42) → no en_in; PCUPD with pc_ctrl=10, offset_addr=0x42, 3 cycles total.
- instr=16'hB000 (illegal) → err=1, PC increments, execution continues. Then instr=16'hF000 → halted=1, busy=0, later start ignored.
- CU_WDOG_EN build, dp_done withheld → err=1 and halted=1 after 15 WAIT cycles, reg_en never asserted. Without the macro → WAIT persists past 100 cycles.
